// File: rtl/tdm_pkg.sv
// Shared types and sizing for the 4-channel TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds a fifth even-parity slot per frame.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int TDM_NCH    = 4;
  localparam int TDM_SLOT_W = 3;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int TDM_NSLOTS = 5;
`else
  localparam int TDM_NSLOTS = 4;
`endif
  localparam int TDM_MISS_W = 3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: clear, jump to slot 1, or advance with wrap.
// Frame length follows TDM_DEMUX_PARITY_EN through tdm_pkg.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load1,
  input  logic                  clr,
  output logic [TDM_SLOT_W-1:0] slot,
  output logic                  last
);

  localparam logic [TDM_SLOT_W-1:0] LAST_SLOT =
    TDM_SLOT_W'(TDM_NSLOTS - 1);

  assign last = (slot == LAST_SLOT);

  // slot register: clear wins over re-align, re-align over advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= TDM_SLOT_W'(1);
    end else if (en) begin
      slot <= last ? '0 : slot + TDM_SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer with frame-sync lock tracking.
// TDM_DEMUX_PARITY_EN: 5-slot frames, even parity, par_err output.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int MISS_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sin,
  input  logic                  frame_sync,
  output logic [TDM_NCH-1:0]    y,
  output logic                  y_valid,
  output logic [TDM_SLOT_W-1:0] slot,
  output logic                  locked,
`ifdef TDM_DEMUX_PARITY_EN
  output logic                  par_err,
`endif
  output logic                  sync_err
);

  state_t                  state_q, state_d;
  logic [TDM_NSLOTS-1:0]   asm_q, asm_d, cap;
  logic [TDM_MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic [TDM_NCH-1:0]      y_d;
  logic                    yv_d, serr_d, perr_d;
  logic                    load1, clr, adv, last;

  tdm_slot_counter u_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .load1 (load1),
    .clr   (clr),
    .slot  (slot),
    .last  (last)
  );

  assign locked   = (state_q == LOCKED);
  assign miss_inc = miss_q + TDM_MISS_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // next state, capture, sync checks and word completion
  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    miss_d  = miss_q;
    y_d     = y;
    yv_d    = 1'b0;
    serr_d  = 1'b0;
    perr_d  = 1'b0;
    load1   = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    cap     = asm_q;
    for (int i = 0; i < TDM_NSLOTS; i++) begin
      if (slot == TDM_SLOT_W'(i)) cap[i] = sin;
    end
    if (en) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          asm_d    = '0;
          asm_d[0] = sin;
          load1    = 1'b1;
          miss_d   = '0;
          state_d  = LOCKED;
        end
      end else if (frame_sync && slot != '0) begin
        serr_d   = 1'b1;
        asm_d    = '0;
        asm_d[0] = sin;
        load1    = 1'b1;
      end else if (!frame_sync && slot == '0 &&
                   miss_inc == TDM_MISS_W'(MISS_LIMIT)) begin
        state_d = HUNT;
        clr     = 1'b1;
        miss_d  = '0;
        asm_d   = '0;
      end else begin
        adv   = 1'b1;
        asm_d = cap;
        if (slot == '0) miss_d = frame_sync ? '0 : miss_inc;
        if (last) begin
`ifdef TDM_DEMUX_PARITY_EN
          if ((^cap[TDM_NCH-1:0]) == cap[TDM_NSLOTS-1]) begin
            y_d  = cap[TDM_NCH-1:0];
            yv_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
`else
          y_d  = cap[TDM_NCH-1:0];
          yv_d = 1'b1;
`endif
        end
      end
    end
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q    <= '0;
      miss_q   <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      sync_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      asm_q    <= asm_d;
      miss_q   <= miss_d;
      y        <= y_d;
      y_valid  <= yv_d;
      sync_err <= serr_d;
`ifdef TDM_DEMUX_PARITY_EN
      par_err  <= perr_d;
`endif
    end
  end

`ifndef TDM_DEMUX_PARITY_EN
  logic unused_perr;
  assign unused_perr = perr_d;
`endif

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receiving end of the 4:1 select-driven mux link. It samples a serial TDM bit stream, where one bit per slot comes from channels 0..3 in order, aligns to a frame-sync pulse, and reassembles each frame into a 4-bit parallel word. It sits between the serial link input and the parallel consumer logic, and reports lock and alignment status.

## Interface
Parameters:
- MISS_LIMIT, default 3: consecutive frames with missing `frame_sync` tolerated before lock is dropped (range 1..7).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  bit strobe; `sin`/`frame_sync` sampled only on cycles with `en`=1.
- sin  in  1  serial TDM data bit.
- frame_sync  in  1  high with the slot-0 bit of a frame.
- y  out  4  last complete word; `y[i]` = bit received in slot i.
- y_valid  out  1  one-cycle pulse when `y` updates.
- slot  out  3  index of the slot expected at the next `en` strobe.
- locked  out  1  high in LOCKED state.
- sync_err  out  1  one-cycle pulse on misaligned `frame_sync`.

## Operation
- States: HUNT, LOCKED.
- HUNT: `en`=1 and `frame_sync`=0 are ignored. On `en`=1 with `frame_sync`=1:
  - `sin` goes to assembly bit 0.
  - `slot` becomes 1, state becomes LOCKED, miss counter is cleared.
- LOCKED, on each `en`=1:
  - `sin` goes to assembly bit `slot`.
  - `slot` increments and wraps after the last slot (3, or 4 with parity).
- Frame completion: when the last slot is captured, `y` loads the assembled word and `y_valid` pulses.
- Sync checks in LOCKED, all qualified by `en`=1:
  - `frame_sync`=1 while `slot`≠0: pulse `sync_err`, discard the partial word (no `y_valid`), treat the bit as slot 0 and set `slot` to 1. The miss counter is unchanged.
  - `frame_sync`=1 at `slot`=0: clear the miss counter.
  - `frame_sync`=0 at `slot`=0: increment the miss counter and still capture the bit as slot 0.
- Lock loss: when the miss counter reaches MISS_LIMIT, the state goes to HUNT in that cycle.
  - The bit is not captured and `slot` becomes 0.
  - `locked` falls on the next edge. `y` holds its value.
- `en`=0: no state, slot, or counter changes. `y_valid` and `sync_err` are 0.

## Timing
- Reset values: `y`=0, `y_valid`=0, `slot`=0, `locked`=0, `sync_err`=0, state HUNT, miss counter 0, assembly register 0.
- Reset asserted mid-frame discards the partial word immediately and asynchronously.
- All outputs are registered.
- Latency: `y`/`y_valid` appear on the clock edge that samples the last slot bit, so they are visible 1 cycle after that strobe.
- `sync_err` and `locked` have the same edge-registered timing.
- `y_valid` never pulses on two consecutive cycles unless `en` strobes on consecutive cycles and the frame is one slot long. That cannot occur, so the minimum spacing is 4 strobes.
- Simultaneous events:
  - Misaligned `frame_sync` on the would-be last slot: the re-alignment wins and no word is emitted.
  - Lock-loss and completion cannot coincide, because a miss occurs only at slot 0.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- Defined:
  - The frame is 5 slots, and slot 4 carries the even-parity bit over slots 0..3.
  - On completion, `y` updates and `y_valid` pulses only when parity matches.
  - On a mismatch, `y` holds and output `par_err` (1 bit, reset 0) pulses for one cycle.
  - `slot` wraps 4→0.
- Undefined:
  - The frame is 4 slots, `slot` wraps 3→0, and there is no `par_err` port.
  - `slot` stays 3 bits wide, with the MSB always 0.

## Structure
- Package `tdm_pkg`:
  - state enum (HUNT, LOCKED);
  - `TDM_NCH`=4;
  - `TDM_SLOT_W`=3;
  - `TDM_NSLOTS` (4, or 5 under the macro);
  - miss-counter width 3.
- Sub-module `tdm_slot_counter`:
  - inputs: `clk`, `rst_n`, `en`, `load1`, `clr`;
  - outputs: `slot` and `last` (high at the final slot);
  - wraps at `TDM_NSLOTS`.
- Top level holds the FSM, assembly register, miss counter, and output registers.

## Test plan
- Aligned frames, `en` every cycle, data 1,0,1,1 with sync on the first bit → `y`=4'b1101 and `y_valid` 1 cycle after the 4th bit. `locked`=1 from the 2nd cycle.
- `en` toggling 1,0,1,0 with the same frame → identical `y`; `slot` holds on `en`=0 cycles and `y_valid` appears 1 cycle after the 4th strobe.
- `frame_sync` reasserted at `slot`=2 → `sync_err` pulse, no `y_valid` for that frame, next four bits 0,1,1,0 → `y`=4'b0110.
- Sync removed, MISS_LIMIT=3 → after the 3rd missing slot-0 sync `locked`=0 and `slot`=0 with `y` held. The next sync relocks.
- `rst_n` low at `slot`=2 → all outputs 0 immediately. After release, the first sync starts a fresh frame.
- With `TDM_DEMUX_PARITY_EN`:
  - data 1,1,0,0 plus parity 0 → `y`=4'b0011 with `y_valid`;
  - data 1,1,0,0 plus parity 1 → `par_err` pulse and `y` unchanged.
